// File: rtl/usart_pkg.sv
// usart_pkg: shared receiver FSM states, oversampling ratios and majority sample points
package usart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
    localparam int OS16_N  = 16;
    localparam int OS16_S0 = 7;
    localparam int OS16_S1 = 8;
    localparam int OS16_S2 = 9;
    localparam int OS8_N   = 8;
    localparam int OS8_S0  = 3;
    localparam int OS8_S1  = 4;
    localparam int OS8_S2  = 5;
endpackage

// File: rtl/usart_rx_if.sv
// usart_rx_if: host-side read port and status flags of the receiver
interface usart_rx_if #(parameter int DATA_W = 8);
    logic              i_RD;
    logic [DATA_W-1:0] o_RXDATA;
    logic              o_RXNE;
    logic              o_FE;
    logic              o_NE;
    logic              o_ORE;
    logic              o_BUSY;
    modport master (output i_RD, input o_RXDATA, o_RXNE, o_FE, o_NE, o_ORE, o_BUSY);
    modport slave  (input i_RD, output o_RXDATA, o_RXNE, o_FE, o_NE, o_ORE, o_BUSY);
endinterface

// File: rtl/usart_rx_sync.sv
// usart_rx_sync: SYNC_STAGES flop chain for an asynchronous input, resets to idle-high
module usart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_CLK,
    input  logic i_RST_B,
    input  logic i_D,
    output logic o_Q
);
    logic [SYNC_STAGES-1:0] r_q;
    always_ff @(posedge i_CLK or negedge i_RST_B)
        if (!i_RST_B) r_q <= '1;
        else          r_q <= {r_q[SYNC_STAGES-2:0], i_D};
    assign o_Q = r_q[SYNC_STAGES-1];
endmodule

// File: rtl/usart_rx.sv
// usart_rx: oversampling async serial receiver, 8N1-style frames with
// 3-sample majority voting, framing/noise/overrun flags and a one-deep data register
module usart_rx import usart_pkg::*; #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic      i_CLK,
    input  logic      i_RST_B,
    input  logic      i_BRGCLK,
    input  logic      i_OVER8,
    input  logic      i_RX,
    usart_rx_if.slave bus
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    rx_state_e         r_state, w_next;
    logic              w_rxs, r_prev, r_over8, r_s0, r_s1, r_noise, r_busy;
    logic [3:0]        r_cnt, w_last, w_s0, w_s1, w_s2;
    logic [BW-1:0]     r_bitn;
    logic [DATA_W-1:0] r_shift, r_data;
    logic              r_rxne, r_fe, r_ne, r_ore;
    logic              w_start, w_at_s2, w_at_last, w_maj, w_noisy, w_done;

    usart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_CLK   (i_CLK),
        .i_RST_B (i_RST_B),
        .i_D     (i_RX),
        .o_Q     (w_rxs)
    );

    assign w_last = r_over8 ? 4'(OS8_N - 1) : 4'(OS16_N - 1);
    assign w_s0   = r_over8 ? 4'(OS8_S0)    : 4'(OS16_S0);
    assign w_s1   = r_over8 ? 4'(OS8_S1)    : 4'(OS16_S1);
    assign w_s2   = r_over8 ? 4'(OS8_S2)    : 4'(OS16_S2);

    always_ff @(posedge i_CLK or negedge i_RST_B)
        if (!i_RST_B) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next != IDLE;
        end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = START;
            START:   if (w_at_s2 && w_maj) w_next = IDLE;
                     else if (w_at_last) w_next = DATA;
            DATA:    if (w_at_last && r_bitn == BW'(DATA_W - 1)) w_next = STOP;
            STOP:    if (w_at_s2) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // third sample is the live synchronised value, the first two are held
    always_comb begin
        w_start   = i_BRGCLK && r_state == IDLE && r_prev && !w_rxs;
        w_at_s2   = i_BRGCLK && r_state != IDLE && r_cnt == w_s2;
        w_at_last = i_BRGCLK && r_state != IDLE && r_cnt == w_last;
        w_maj     = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
        w_noisy   = (r_s0 | r_s1 | w_rxs) && !(r_s0 & r_s1 & w_rxs);
        w_done    = w_at_s2 && r_state == STOP;
    end

    // r_prev resets low so a line held low through reset never looks like a start edge
    always_ff @(posedge i_CLK or negedge i_RST_B)
        if (!i_RST_B) begin
            r_prev  <= 1'b0;
            r_over8 <= 1'b0;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_noise <= 1'b0;
            r_shift <= '0;
        end else begin
            if (i_BRGCLK) r_prev <= w_rxs;
            if (w_start) begin
                r_over8 <= i_OVER8;
                r_cnt   <= 4'd1;
                r_bitn  <= '0;
                r_noise <= 1'b0;
            end else if (i_BRGCLK && r_state != IDLE) begin
                r_cnt <= w_at_last ? 4'd0 : r_cnt + 4'd1;
                if (r_cnt == w_s0) r_s0 <= w_rxs;
                if (r_cnt == w_s1) r_s1 <= w_rxs;
                if (w_at_s2 && w_noisy) r_noise <= 1'b1;
                if (w_at_s2 && r_state == DATA) r_shift <= {w_maj, r_shift[DATA_W-1:1]};
                if (w_at_last && r_state == DATA) r_bitn <= r_bitn + BW'(1);
            end
        end

    always_ff @(posedge i_CLK or negedge i_RST_B)
        if (!i_RST_B) begin
            r_data <= '0;
            r_rxne <= 1'b0;
            r_fe   <= 1'b0;
            r_ne   <= 1'b0;
            r_ore  <= 1'b0;
        end else if (w_done && (!r_rxne || bus.i_RD)) begin
            r_data <= r_shift;
            r_rxne <= 1'b1;
            r_fe   <= !w_maj;
            r_ne   <= r_noise | w_noisy;
            r_ore  <= 1'b0;
        end else if (w_done) begin
            r_ore  <= 1'b1;
        end else if (bus.i_RD) begin
            r_rxne <= 1'b0;
            r_fe   <= 1'b0;
            r_ne   <= 1'b0;
            r_ore  <= 1'b0;
        end

    assign bus.o_RXDATA = r_data;
    assign bus.o_RXNE   = r_rxne;
    assign bus.o_FE     = r_fe;
    assign bus.o_NE     = r_ne;
    assign bus.o_ORE    = r_ore;
    assign bus.o_BUSY   = r_busy;
endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed frames with a scoreboard queue checked by an output monitor
module tb_usart_rx;
    logic clk = 1'b0, rst_n = 1'b1, brg = 1'b0, over8 = 1'b0, rx = 1'b1;
    int n_cmp = 0, n_bad = 0;
    logic [10:0] exp_q[$];

    usart_rx_if #(.DATA_W(8)) bus();
    usart_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_CLK   (clk),
        .i_RST_B (rst_n),
        .i_BRGCLK(brg),
        .i_OVER8 (over8),
        .i_RX    (rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // one oversample period: line set, then a single-cycle tick three cycles later
    task automatic slot(input logic v);
        rx = v;
        repeat (3) @(negedge clk);
        brg = 1'b1;
        @(negedge clk);
        brg = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) slot(1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic ov, input logic stopv,
                        input int nb, input int ns, input bit lat);
        int n = ov ? 8 : 16;
        int s2 = ov ? 5 : 9;
        logic [9:0] fr = {stopv, d, 1'b0};
        over8 = ov;
        for (int b = 0; b < 10; b++)
            for (int j = 0; j < n; j++) begin
                slot((b == nb && j == ns) ? ~fr[b] : fr[b]);
                if (lat && b == 9 && j == s2 - 1) check("rxne_before_stop_s2", 32'(bus.o_RXNE), 32'd0);
                if (lat && b == 9 && j == s2)     check("rxne_after_stop_s2", 32'(bus.o_RXNE), 32'd1);
            end
    endtask

    task automatic rd_pulse();
        bus.i_RD = 1'b1;
        @(negedge clk);
        bus.i_RD = 1'b0;
    endtask

    task automatic wait_rxne(input string nm);
        int k = 0;
        while (!bus.o_RXNE && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check(nm, 32'(bus.o_RXNE), 32'd1);
    endtask

    initial begin
        logic pr = 1'b0, po = 1'b0;
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if ((bus.o_RXNE && !pr) || (bus.o_ORE && !po)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: actual %0h required none",
                             {bus.o_RXDATA, bus.o_FE, bus.o_NE, bus.o_ORE});
                end else begin
                    e = exp_q.pop_front();
                    check("frame{data,fe,ne,ore}", 32'({bus.o_RXDATA, bus.o_FE, bus.o_NE, bus.o_ORE}), 32'(e));
                end
            end
            pr = bus.o_RXNE;
            po = bus.o_ORE;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] ab = {1'b1, 8'h6E, 1'b0};
        bus.i_RD = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.o_RXDATA, bus.o_RXNE, bus.o_FE, bus.o_NE, bus.o_ORE, bus.o_BUSY}), 32'd0);
        rst_n = 1'b1;
        idle(4);

        exp_q.push_back({8'hA5, 3'b000});
        send(8'hA5, 1'b0, 1'b1, -1, 0, 1'b1);
        idle(4);
        rd_pulse();
        check("rd_clears_rxne", 32'(bus.o_RXNE), 32'd0);

        exp_q.push_back({8'h3C, 3'b000});
        exp_q.push_back({8'hC3, 3'b000});
        fork
            begin
                send(8'h3C, 1'b1, 1'b1, -1, 0, 1'b0);
                send(8'hC3, 1'b1, 1'b1, -1, 0, 1'b0);
            end
            begin
                repeat (2) begin
                    wait_rxne("b2b_rxne_wait");
                    rd_pulse();
                end
            end
        join
        idle(4);
        check("b2b_idle_busy", 32'(bus.o_BUSY), 32'd0);

        over8 = 1'b0;
        slot(1'b0);
        check("glitch_busy_high", 32'(bus.o_BUSY), 32'd1);
        slot(1'b0);
        slot(1'b0);
        idle(12);
        check("glitch_busy_low", 32'(bus.o_BUSY), 32'd0);
        check("glitch_rxne", 32'(bus.o_RXNE), 32'd0);

        exp_q.push_back({8'h55, 3'b100});
        send(8'h55, 1'b0, 1'b0, -1, 0, 1'b0);
        idle(16);
        rd_pulse();
        check("rd_clears_fe", 32'(bus.o_FE), 32'd0);

        exp_q.push_back({8'h0F, 3'b010});
        send(8'h0F, 1'b0, 1'b1, 4, 8, 1'b0);
        idle(4);
        rd_pulse();
        check("rd_clears_ne", 32'(bus.o_NE), 32'd0);

        exp_q.push_back({8'h11, 3'b000});
        send(8'h11, 1'b0, 1'b1, -1, 0, 1'b0);
        idle(4);
        exp_q.push_back({8'h11, 3'b001});
        send(8'h22, 1'b0, 1'b1, -1, 0, 1'b0);
        idle(4);
        check("ore_keeps_data", 32'(bus.o_RXDATA), 32'h11);
        rd_pulse();
        check("rd_clears_flags", 32'({bus.o_RXNE, bus.o_FE, bus.o_NE, bus.o_ORE}), 32'd0);

        exp_q.push_back({8'h5A, 3'b000});
        send(8'h5A, 1'b0, 1'b1, -1, 0, 1'b0);
        idle(4);
        for (int b = 0; b < 5; b++)
            for (int j = 0; j < ((b == 4) ? 6 : 16); j++)
                slot(ab[b]);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'({bus.o_RXDATA, bus.o_RXNE, bus.o_FE, bus.o_NE, bus.o_ORE, bus.o_BUSY}), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        exp_q.push_back({8'h81, 3'b000});
        send(8'h81, 1'b0, 1'b1, -1, 0, 1'b0);
        idle(4);
        rd_pulse();

        idle(8);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
